// File: rtl/dispatch_stage_if.sv
// Shared uop type and the valid/ready uop channel used by dispatch_stage.
// types_pkg::rename_data is the renamed uop carried from rename to the issue queues.
// The master side drives a uop plus its source-ready bits; the slave side
// consumes a bare uop (rename -> dispatch) and returns ready.

package types_pkg;
   localparam int PREG_W = 7;
   localparam int ROB_W  = 6;

   typedef struct packed {
      logic [ROB_W-1:0]  rob_tag;
      logic [PREG_W-1:0] pd_old;
      logic [PREG_W-1:0] pd_new;
      logic [PREG_W-1:0] ps2;
      logic [PREG_W-1:0] ps1;
      logic [1:0]        fu;
   } rename_data;
endpackage

interface dispatch_stage_if;
   import types_pkg::*;

   logic       valid;
   rename_data data;
   logic       ready;
   logic       rs1_rdy;
   logic       rs2_rdy;

   modport master (output valid, output data, output rs1_rdy, output rs2_rdy, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dispatch_stage.sv
// dispatch_stage: takes renamed uops from rename, allocates the ROB entry on
// acceptance, annotates source readiness from a physical-register busy table
// (with same-cycle CDB bypass) and routes each uop by fu to one registered
// slot per issue port (ALU / BRU / LSU).
// Optional feature macro: DISPATCH_STATS_EN adds saturating stall_cycles and
// flush_count outputs.

module dispatch_stage #(
   parameter int NUM_PREG = 128,
   parameter int PREG_W   = 7,
   parameter int NUM_CDB  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   dispatch_stage_if.slave           rn,
   input  logic                      mispredict,
   input  logic [NUM_CDB-1:0]        cdb_valid,
   input  logic [NUM_CDB*PREG_W-1:0] cdb_preg,
   input  logic                      rob_ready,
   output logic                      rob_alloc,
   dispatch_stage_if.master          alu,
   dispatch_stage_if.master          bru,
   dispatch_stage_if.master          lsu
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]               stall_cycles,
   output logic [15:0]               flush_count
`endif
);
   import types_pkg::*;

   localparam int NPORT = 3;

   logic [NPORT-1:0]    valid_r;
   logic [NPORT-1:0]    rs1_rdy_r;
   logic [NPORT-1:0]    rs2_rdy_r;
   rename_data          data_r [NPORT];
   logic [NPORT-1:0]    port_ready_s;
   logic [NPORT-1:0]    slot_free_s;
   logic [NPORT-1:0]    load_s;
   logic                ready_s;
   logic                accept_s;
   logic                in_rs1_s;
   logic                in_rs2_s;
   logic [NUM_PREG-1:0] busy_r;
   logic [NUM_PREG-1:0] busy_nxt_s;
   logic [NUM_PREG-1:0] cdb_clr_s;
   logic [NUM_PREG-1:0] alloc_set_s;

   // True when any valid writeback port broadcasts physical register ps.
   function automatic logic cdb_hit(input logic [PREG_W-1:0] ps,
                                    input logic [NUM_CDB-1:0] cv,
                                    input logic [NUM_CDB*PREG_W-1:0] cp);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         hit = hit | (cv[k] && (cp[k*PREG_W +: PREG_W] == ps));
      end
      return hit;
   endfunction

   // Source is ready if p0, not busy, or being written back this very cycle.
   function automatic logic src_ready(input logic [PREG_W-1:0] ps,
                                      input logic [NUM_PREG-1:0] busy,
                                      input logic [NUM_CDB-1:0] cv,
                                      input logic [NUM_CDB*PREG_W-1:0] cp);
      return (ps == {PREG_W{1'b0}}) || !busy[ps] || cdb_hit(ps, cv, cp);
   endfunction

   assign port_ready_s = {lsu.ready, bru.ready, alu.ready};

   // Acceptance: the target slot must be free, the ROB must have room, no flush; fu=3 never accepted.
   always_comb begin
      slot_free_s = ~valid_r | port_ready_s;
      ready_s     = 1'b0;
      load_s      = 3'b000;
      case (rn.data.fu)
         2'd0:    ready_s = slot_free_s[0];
         2'd1:    ready_s = slot_free_s[1];
         2'd2:    ready_s = slot_free_s[2];
         default: ready_s = 1'b0;
      endcase
      ready_s  = ready_s && rob_ready && !mispredict;
      accept_s = rn.valid && ready_s;
      if (accept_s) begin
         load_s = 3'b001 << rn.data.fu;
      end else begin
         load_s = 3'b000;
      end
      in_rs1_s = src_ready(rn.data.ps1, busy_r, cdb_valid, cdb_preg);
      in_rs2_s = src_ready(rn.data.ps2, busy_r, cdb_valid, cdb_preg);
   end

   assign rn.ready  = ready_s;
   assign rob_alloc = accept_s;

   // Next busy table: writebacks clear first, a new allocation then sets (set wins), p0 never busy.
   always_comb begin
      cdb_clr_s   = '0;
      alloc_set_s = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         cdb_clr_s[cdb_preg[k*PREG_W +: PREG_W]] = cdb_clr_s[cdb_preg[k*PREG_W +: PREG_W]] | cdb_valid[k];
      end
      alloc_set_s[rn.data.pd_new] = accept_s;
      busy_nxt_s    = (busy_r & ~cdb_clr_s) | alloc_set_s;
      busy_nxt_s[0] = 1'b0;
   end

   // Busy table register; not restored on mispredict, squashed pregs clear on their next writeback.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // Per-port output slots: load on accept, drain on downstream ready, flush on mispredict, held slots snoop the CDB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r   <= '0;
         rs1_rdy_r <= '0;
         rs2_rdy_r <= '0;
         for (int i = 0; i < NPORT; i++) begin
            data_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            if (load_s[i]) begin
               valid_r[i]   <= 1'b1;
               data_r[i]    <= rn.data;
               rs1_rdy_r[i] <= in_rs1_s;
               rs2_rdy_r[i] <= in_rs2_s;
            end else begin
               valid_r[i]   <= valid_r[i] && !port_ready_s[i] && !mispredict;
               rs1_rdy_r[i] <= rs1_rdy_r[i] | cdb_hit(data_r[i].ps1, cdb_valid, cdb_preg);
               rs2_rdy_r[i] <= rs2_rdy_r[i] | cdb_hit(data_r[i].ps2, cdb_valid, cdb_preg);
            end
         end
      end
   end

   assign alu.valid   = valid_r[0];
   assign alu.data    = data_r[0];
   assign alu.rs1_rdy = rs1_rdy_r[0];
   assign alu.rs2_rdy = rs2_rdy_r[0];
   assign bru.valid   = valid_r[1];
   assign bru.data    = data_r[1];
   assign bru.rs1_rdy = rs1_rdy_r[1];
   assign bru.rs2_rdy = rs2_rdy_r[1];
   assign lsu.valid   = valid_r[2];
   assign lsu.data    = data_r[2];
   assign lsu.rs1_rdy = rs1_rdy_r[2];
   assign lsu.rs2_rdy = rs2_rdy_r[2];

`ifdef DISPATCH_STATS_EN
   logic [31:0] stall_cycles_r;
   logic [15:0] flush_count_r;

   // Saturating counters: stalled valid uops (excluding flush cycles) and mispredict cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_r <= 32'd0;
         flush_count_r  <= 16'd0;
      end else begin
         if (rn.valid && !ready_s && !mispredict && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
         if (mispredict && (flush_count_r != 16'hFFFF)) begin
            flush_count_r <= flush_count_r + 16'd1;
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

   assign stall_cycles = stall_cycles_r;
   assign flush_count  = flush_count_r;
`endif

endmodule
